// File: rtl/mac_vec_engine_if.sv
// mac_vec_engine_if
//   Stream bundle between the HWPE streamer and mac_vec_engine.
//   a, b, c are operand streams into the engine; d is the result stream out.
//   Each data word packs N_LANES signed lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH].
//   Modports:
//     master - streamer side: drives a/b/c data+valid and d_ready_i.
//     slave  - engine side: drives a/b/c ready and d data+valid.
interface mac_vec_engine_if #(
  parameter int N_LANES    = 4,
  parameter int DATA_WIDTH = 16
);
  logic [N_LANES*DATA_WIDTH-1:0] a_data_i;
  logic                          a_valid_i;
  logic                          a_ready_o;
  logic [N_LANES*DATA_WIDTH-1:0] b_data_i;
  logic                          b_valid_i;
  logic                          b_ready_o;
  logic [N_LANES*DATA_WIDTH-1:0] c_data_i;
  logic                          c_valid_i;
  logic                          c_ready_o;
  logic [N_LANES*DATA_WIDTH-1:0] d_data_o;
  logic                          d_valid_o;
  logic                          d_ready_i;

  modport master (
    output a_data_i, a_valid_i, b_data_i, b_valid_i, c_data_i, c_valid_i, d_ready_i,
    input  a_ready_o, b_ready_o, c_ready_o, d_data_o, d_valid_o
  );

  modport slave (
    input  a_data_i, a_valid_i, b_data_i, b_valid_i, c_data_i, c_valid_i, d_ready_i,
    output a_ready_o, b_ready_o, c_ready_o, d_data_o, d_valid_o
  );
endinterface

// File: rtl/mac_vec_engine.sv
// mac_vec_engine
//   N_LANES parallel signed multiply-accumulate engine controlled by an HWPE
//   controller. Mode 0 (ACCUMULATE) sums a*b over len beats per lane, then adds
//   one c beat and emits a single d beat. Mode 1 (MULTIPLY) emits one d beat per
//   a/b/c beat: d = a*b + c. The result is arithmetically shifted right by shift
//   and formatted to DATA_WIDTH bits.
//   Optional feature: define MAC_VEC_SAT_EN to saturate each output lane instead
//   of truncating it (two's complement wrap).
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous soft clear (same effect as reset, top priority)
//   start_i             job start, sampled in IDLE only
//   mode_i, len_i,
//   shift_i             job configuration, latched at start
//   strm (slave)        a/b/c operand streams in, d result stream out
//   busy_o              high whenever not IDLE
//   done_o              one-cycle pulse at job end
//   cnt_o               a/b beats consumed in the current job
module mac_vec_engine #(
  parameter int N_LANES    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 16,
  localparam int SHIFT_W   = $clog2(ACC_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  mac_vec_engine_if.slave      strm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  localparam int VW = N_LANES*DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACC, ADDC, OUT} state_t;

  state_t                       state;
  logic                         mode_q;
  logic [CNT_WIDTH-1:0]         len_q;
  logic [SHIFT_W-1:0]           shift_q;
  logic [CNT_WIDTH-1:0]         cnt_q;
  logic signed [ACC_WIDTH-1:0]  acc_p0 [N_LANES];
  logic [VW-1:0]                d_p1;
  logic                         vld_p1;
  logic                         done_q;

`ifdef MAC_VEC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  // Output formatting of an already shifted lane value.
  function automatic logic signed [DATA_WIDTH-1:0] fmt(input logic signed [ACC_WIDTH-1:0] v);
`ifdef MAC_VEC_SAT_EN
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  // ---- stage p0: lane products, accumulator update, result formatting ----
  logic signed [DATA_WIDTH-1:0]   a_l [N_LANES];
  logic signed [DATA_WIDTH-1:0]   b_l [N_LANES];
  logic signed [DATA_WIDTH-1:0]   c_l [N_LANES];
  logic signed [2*DATA_WIDTH-1:0] prod [N_LANES];
  logic signed [ACC_WIDTH-1:0]    prod_ext [N_LANES];
  logic signed [ACC_WIDTH-1:0]    c_ext [N_LANES];
  logic signed [ACC_WIDTH-1:0]    acc_nxt [N_LANES];
  logic [VW-1:0]                  mul_res;
  logic [VW-1:0]                  addc_res;

  always_comb begin
    mul_res  = '0;
    addc_res = '0;
    for (int k = 0; k < N_LANES; k++) begin
      a_l[k]      = $signed(strm.a_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
      b_l[k]      = $signed(strm.b_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
      c_l[k]      = $signed(strm.c_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
      prod[k]     = (2*DATA_WIDTH)'(a_l[k]) * (2*DATA_WIDTH)'(b_l[k]);
      prod_ext[k] = ACC_WIDTH'(prod[k]);
      c_ext[k]    = ACC_WIDTH'(c_l[k]);
      acc_nxt[k]  = acc_p0[k] + prod_ext[k];
      mul_res[k*DATA_WIDTH +: DATA_WIDTH]  = fmt((prod_ext[k] + c_ext[k]) >>> shift_q);
      addc_res[k*DATA_WIDTH +: DATA_WIDTH] = fmt((acc_p0[k] + c_ext[k]) >>> shift_q);
    end
  end

  // Joined handshakes: operands are only taken together, never partially.
  // In MULTIPLY the beat also needs room in the d register (free or draining).
  logic ab_rdy;
  logic c_rdy;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  always_comb begin
    ab_rdy = 1'b0;
    c_rdy  = 1'b0;
    if (state == ACC) begin
      if (mode_q) begin
        ab_rdy = strm.a_valid_i & strm.b_valid_i & strm.c_valid_i &
                 (~vld_p1 | strm.d_ready_i);
        c_rdy  = ab_rdy;
      end else begin
        ab_rdy = strm.a_valid_i & strm.b_valid_i;
      end
    end else if (state == ADDC) begin
      c_rdy = 1'b1;
    end
  end

  assign cnt_nxt = cnt_q + 1'b1;

  // ---- stage p1: control FSM, accumulators and d output register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      d_p1    <= '0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < N_LANES; k++) acc_p0[k] <= '0;
    end else if (clear_i) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      d_p1    <= '0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < N_LANES; k++) acc_p0[k] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            len_q   <= len_i;
            shift_q <= shift_i;
            cnt_q   <= '0;
            for (int k = 0; k < N_LANES; k++) acc_p0[k] <= '0;
            // An empty job finishes immediately without producing a d beat.
            if (len_i == '0) done_q <= 1'b1;
            else             state  <= ACC;
          end
        end
        ACC: begin
          if (mode_q) begin
            if (ab_rdy) begin
              d_p1   <= mul_res;
              vld_p1 <= 1'b1;
              cnt_q  <= cnt_nxt;
              if (cnt_nxt == len_q) state <= OUT;
            end else if (vld_p1 && strm.d_ready_i) begin
              vld_p1 <= 1'b0;
            end
          end else if (ab_rdy) begin
            for (int k = 0; k < N_LANES; k++) acc_p0[k] <= acc_nxt[k];
            cnt_q <= cnt_nxt;
            if (cnt_nxt == len_q) state <= ADDC;
          end
        end
        ADDC: begin
          if (strm.c_valid_i) begin
            d_p1   <= addc_res;
            vld_p1 <= 1'b1;
            state  <= OUT;
          end
        end
        OUT: begin
          // done rises only as d_valid falls, never alongside a new d beat.
          if (strm.d_ready_i) begin
            vld_p1 <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign strm.a_ready_o = ab_rdy;
  assign strm.b_ready_o = ab_rdy;
  assign strm.c_ready_o = c_rdy;
  assign strm.d_data_o  = d_p1;
  assign strm.d_valid_o = vld_p1;
  assign busy_o         = (state != IDLE);
  assign done_o         = done_q;
  assign cnt_o          = cnt_q;

endmodule

// File: tb/tb_mac_vec_engine.sv
// tb_mac_vec_engine
//   Self-checking bench for mac_vec_engine: table of whole jobs plus hand-written
//   sequences for reset, backpressure, clear, stall and signed corner cases.
//   Expected d beats go into a scoreboard queue when a job/beat is driven and are
//   popped by a monitor on every d handshake.
`timescale 1ns/1ps
module tb_mac_vec_engine;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int CW  = 16;
  localparam int SHW = $clog2(AW);
  localparam int VW  = N*DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear;
  logic           start;
  logic           mode;
  logic [CW-1:0]  len;
  logic [SHW-1:0] shift;
  logic           busy;
  logic           done;
  logic [CW-1:0]  cnt;

  mac_vec_engine_if #(.N_LANES(N), .DATA_WIDTH(DW)) strm ();

  mac_vec_engine #(
    .N_LANES(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .mode_i(mode), .len_i(len), .shift_i(shift), .strm(strm),
    .busy_o(busy), .done_o(done), .cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit rdy_toggle = 1'b0;
  logic [VW-1:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input int v);
    logic [DW-1:0] t;
    t = v[DW-1:0];
    return {N{t}};
  endfunction

  // d_ready: held high, or toggled every cycle for backpressure tests.
  always @(posedge clk) begin
    #1;
    strm.d_ready_i = rdy_toggle ? ~strm.d_ready_i : 1'b1;
  end

  // Monitor: scoreboard pop on d handshake, done pulse counting.
  always @(negedge clk) begin
    if (rst_n) begin
      if (strm.d_valid_o && strm.d_ready_i) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL d_unexpected: got d=%0h with empty scoreboard", strm.d_data_o);
        end else begin
          check("d_data", strm.d_data_o, sb_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("done_with_dvalid", strm.d_valid_o, 1'b0);
      end
    end
  end

  task automatic set_valids(input bit va, input bit vb, input bit vc);
    strm.a_valid_i = va;
    strm.b_valid_i = vb;
    strm.c_valid_i = vc;
  endtask

  task automatic pulse_start(input bit m, input int n, input int sh);
    mode  = m;
    len   = n[CW-1:0];
    shift = sh[SHW-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one beat and hold it until the engine takes it (bounded).
  task automatic beat(input bit use_ab, input bit use_c,
                      input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c);
    bit ok;
    strm.a_data_i = a;
    strm.b_data_i = b;
    strm.c_data_i = c;
    set_valids(use_ab, use_ab, use_c);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = use_ab ? strm.a_ready_o : strm.c_ready_o;
      @(posedge clk); #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got no ready in 64 cycles want ready");
    end
  endtask

  task automatic wait_done(input int d0, input string tag);
    int i;
    i = 0;
    while (done_cnt == d0 && i < 64) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic run_job(input bit m, input int n, input int sh,
                         input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [VW-1:0] c, input logic [VW-1:0] dexp,
                         input string tag);
    int d0;
    if (m) for (int i = 0; i < n; i++) sb_q.push_back(dexp);
    else   sb_q.push_back(dexp);
    d0 = done_cnt;
    pulse_start(m, n, sh);
    check({tag, "_busy"}, busy, 1'b1);
    if (m) begin
      for (int i = 0; i < n; i++) beat(1'b1, 1'b1, a, b, c);
    end else begin
      for (int i = 0; i < n; i++) beat(1'b1, 1'b0, a, b, c);
      beat(1'b0, 1'b1, a, b, c);
    end
    set_valids(1'b0, 1'b0, 1'b0);
    wait_done(d0, tag);
    check({tag, "_cnt"}, cnt, 64'(n));
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  typedef struct {
    bit            m;
    int            n;
    int            sh;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [VW-1:0] c;
    logic [VW-1:0] d;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    logic [VW-1:0] t6_exp;

    tbl[0] = '{1'b0, 3, 0, rep(2), rep(2), rep(5), rep(17)};
    tbl[1] = '{1'b1, 1, 0, 64'h0004_FFFE_0064_0007, 64'h0003_0005_FF9C_0000,
               64'h0001_0001_0001_FFF7, 64'h000D_FFF7_D8F1_FFF7};
    tbl[2] = '{1'b0, 3, 1, 64'h0001_0002_FFFD_000A, 64'h0001_0002_0004_000A,
               64'h0000_0001_FFFE_0003, 64'h0001_0006_FFED_0097};
    tbl[3] = '{1'b1, 2, 2, 64'hFFF8_0008_0100_FFFF, 64'h0003_0003_0100_FFFF,
               64'h0, 64'hFFFA_0006_4000_0000};
    tbl[4] = '{1'b1, 1, 0, rep(5), rep(-5), rep(32767), rep(32742)};
`ifdef MAC_VEC_SAT_EN
    tbl[5] = '{1'b0, 2, 4, rep(32767), rep(32767), rep(0), rep(32767)};
`else
    tbl[5] = '{1'b0, 2, 4, rep(32767), rep(32767), rep(0), rep(16'hE000)};
`endif

    clear = 1'b0; start = 1'b0; mode = 1'b0; len = '0; shift = '0;
    strm.a_data_i = '0; strm.b_data_i = '0; strm.c_data_i = '0;
    set_valids(1'b1, 1'b1, 1'b1);

    // T1: reset state, readies stay low in IDLE even with valid operands
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cnt", cnt, 0);
    check("rst_dvalid", strm.d_valid_o, 1'b0);
    check("rst_ddata", strm.d_data_o, 0);
    check("rst_readies", {strm.a_ready_o, strm.b_ready_o, strm.c_ready_o}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_readies", {strm.a_ready_o, strm.b_ready_o, strm.c_ready_o}, 0);
    set_valids(1'b0, 1'b0, 1'b0);

    // T1: zero-length job
    d0 = done_cnt;
    pulse_start(1'b0, 0, 0);
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("len0_done_fall", done, 1'b0);
    check("len0_no_d", strm.d_valid_o, 1'b0);
    @(posedge clk); #1;
    check("len0_done_count", 64'(done_cnt - d0), 64'd1);

    // Table of whole jobs
    for (int i = 0; i < 6; i++)
      run_job(tbl[i].m, tbl[i].n, tbl[i].sh, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d,
              $sformatf("vec%0d", i));

    // T3: multiply with toggling d_ready, a = beat index
    rdy_toggle = 1'b1;
    d0 = done_cnt;
    pulse_start(1'b1, 4, 0);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(rep(3*i + 1));
      beat(1'b1, 1'b1, rep(i), rep(3), rep(1));
    end
    set_valids(1'b0, 1'b0, 1'b0);
    wait_done(d0, "bp");
    rdy_toggle = 1'b0;
    check("bp_cnt", cnt, 4);
    check("bp_sb_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;

    // T5: clear mid-job, start ignored while busy
    d0 = done_cnt;
    pulse_start(1'b0, 5, 0);
    beat(1'b1, 1'b0, rep(1), rep(1), rep(0));
    beat(1'b1, 1'b0, rep(1), rep(1), rep(0));
    set_valids(1'b0, 1'b0, 1'b0);
    check("clr_cnt_before", cnt, 2);
    pulse_start(1'b1, 1, 0);
    check("busy_start_ignored", busy, 1'b1);
    check("busy_start_cnt", cnt, 2);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_busy", busy, 1'b0);
    check("clr_dvalid", strm.d_valid_o, 1'b0);
    check("clr_cnt", cnt, 0);
    check("clr_no_done", 64'(done_cnt - d0), 64'd0);
    run_job(1'b0, 1, 0, rep(3), rep(3), rep(0), rep(9), "post_clr");

    // Asynchronous reset mid-job with a d beat pending
    pulse_start(1'b1, 2, 0);
    beat(1'b1, 1'b1, rep(1), rep(1), rep(1));
    set_valids(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_dvalid", strm.d_valid_o, 1'b0);
    check("arst_ddata", strm.d_data_o, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_cnt", cnt, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T6: signed multiply with a_valid stalled
    d0 = done_cnt;
    pulse_start(1'b1, 1, 0);
    strm.a_data_i = rep(-3);
    strm.b_data_i = rep(5);
    strm.c_data_i = rep(-1);
    set_valids(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_ready%0d", i),
            {strm.a_ready_o, strm.b_ready_o, strm.c_ready_o}, 0);
      @(posedge clk); #1;
    end
    t6_exp = rep(-16);
    sb_q.push_back(t6_exp);
    beat(1'b1, 1'b1, rep(-3), rep(5), rep(-1));
    set_valids(1'b0, 1'b0, 1'b0);
    wait_done(d0, "signed");
    check("signed_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
